sdram_arbiter: RTL
==================

# sdram_arbiter

Two-port request arbiter and refresh scheduler in front of the single-port SDRAM command sequencer. It accepts read/write requests from two system masters (port 0: CPU, port 1: display/DMA), serialises them with round-robin fairness, and inserts periodic auto-refresh requests at highest priority. It presents one command at a time downstream and routes read data and completion back to the winning port.

## Interface
- REF_CYCLES, 1560, clk_100m cycles between refresh requests (15.6 µs at 100 MHz)
- ADDR_W, 24, SDRAM word-address width (bank+row+column)

- clk_100m  in  1  system clock, 100 MHz; all logic rising-edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- p0_req / p1_req  in  1  level request; held until matching ack
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req high
- p0_addr / p1_addr  in  ADDR_W  word address; stable while req high
- p0_wdata / p1_wdata  in  16  write data; stable while req high
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_rdata / p1_rdata  out  16  read data, valid with ack, held until next ack on that port
- sdr_req  out  1  command valid to sequencer, held until sdr_ack
- sdr_ref  out  1  1 = auto-refresh command (we/addr/wdata ignored downstream)
- sdr_we  out  1  latched write flag
- sdr_addr  out  ADDR_W  latched address
- sdr_wdata  out  16  latched write data
- sdr_ack  in  1  one-cycle pulse from sequencer: command finished
- sdr_rdata  in  16  read data, valid in the sdr_ack cycle
- ref_overrun  out  1  sticky: refresh interval expired while previous refresh still pending

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: select in priority order: refresh pending > round-robin among p0_req/p1_req. Round-robin: when both request, the port not served last wins; last-served pointer resets to 1 (port 0 wins first tie). On selection: latch we/addr/wdata (or set sdr_ref=1, we=0) into output registers, record owner (P0, P1, REF), assert sdr_req, go BUSY. No request: stay IDLE.
- BUSY: hold sdr_req and all sdr_* outputs constant. On sdr_ack: drop sdr_req and sdr_ref; if owner is a port, latch sdr_rdata into that port's rdata (writes too; value don't-care for writes) and pulse its ack; update last-served pointer (refresh does not change it); if owner REF, clear refresh pending; go DONE.
- DONE: one idle cycle, no selection, so a requester seeing ack can deassert req before re-arbitration; go IDLE.
- Refresh timer: free-running counter 0..REF_CYCLES-1, wraps; on wrap sets refresh pending. Wrap while pending already set (not yet cleared) sets ref_overrun; pending stays single (no queuing). Clear and set in the same cycle: set wins.
- sdr_ack outside BUSY is ignored.
- A requester dropping req before ack is a protocol violation; the latched command still completes and ack still pulses.

## Timing
- Reset (async assert): state IDLE, all outputs 0 (sdr_req, sdr_ref, sdr_we, sdr_addr, sdr_wdata, pN_ack, pN_rdata, ref_overrun), timer 0, pending 0, pointer 1. Reset mid-BUSY aborts the command; sequencer is reset by the same rst_n.
- Request sampled high at edge k in IDLE → sdr_req high in cycle k+1.
- sdr_ack high in cycle m → pN_ack high in cycle m+1 for exactly one cycle, rdata valid same cycle; IDLE again at cycle m+2; next sdr_req earliest cycle m+3.
- Minimum turnaround (sdr_ack in first BUSY cycle): 3 cycles per command.
- First refresh pending after REF_CYCLES cycles from reset release.

## Test plan
- Single write: p0_req, we=1, addr=0x000123, wdata=0xA5A5; sdr_ack 4 cycles after sdr_req → sdr_addr=0x000123, sdr_wdata=0xA5A5 during BUSY, one p0_ack pulse, p1_ack never.
- Read return: p1 read addr=0x7FFFFF, sdr_rdata=0x1234 with sdr_ack → p1_rdata=0x1234 with p1_ack, held afterwards.
- Contention: p0_req and p1_req held high for 4 commands each → grant order P0,P1,P0,P1…, no port served twice consecutively.
- Refresh priority: REF_CYCLES=16, both ports requesting continuously → sdr_ref=1 command issued at first IDLE after pending set, round-robin order undisturbed.
- Overrun: REF_CYCLES=16, withhold sdr_ack for 20 cycles on a refresh → ref_overrun=1 and stays 1 until rst_n.
- Reset mid-operation: rst_n low during BUSY → all outputs 0 immediately; after release p0 wins a simultaneous request.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Purpose: two-port round-robin request arbiter with periodic auto-refresh injection in front of the SDRAM sequencer.
// Latency: request sampled in IDLE -> sdr_req next cycle; sdr_ack -> port ack next cycle; 3-cycle minimum turnaround.
// Backpressure: one command in flight; sdr_req and sdr_* are held until sdr_ack, and ports wait on level req until their ack.
//
// Ports:
//   clk_100m, rst_n           : clock, async active-low reset
//   pN_req/we/addr/wdata      : level request from port N (0 = CPU, 1 = display/DMA), held until pN_ack
//   pN_ack, pN_rdata          : one-cycle completion pulse; rdata valid with ack and held until the next ack
//   sdr_req/ref/we/addr/wdata : latched command to sequencer, held until sdr_ack
//   sdr_ack, sdr_rdata        : completion pulse and read data from sequencer
//   ref_overrun               : sticky, refresh interval expired while the previous refresh was still pending
module sdram_arbiter #(
    parameter int REF_CYCLES = 1560,
    parameter int ADDR_W     = 24
) (
    input  logic              clk_100m,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [15:0]       p0_wdata,
    output logic              p0_ack,
    output logic [15:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [15:0]       p1_wdata,
    output logic              p1_ack,
    output logic [15:0]       p1_rdata,
    output logic              sdr_req,
    output logic              sdr_ref,
    output logic              sdr_we,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic [15:0]       sdr_wdata,
    input  logic              sdr_ack,
    input  logic [15:0]       sdr_rdata,
    output logic              ref_overrun
);

    localparam int CNT_W = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REF_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OWN_P0, OWN_P1, OWN_REF} owner_t;

    state_t           state, state_nxt;
    owner_t           owner;
    logic [CNT_W-1:0] ref_cnt;
    logic             ref_wrap;
    logic             ref_pend;
    logic             last_p1;     // 1 = port 1 served last, so port 0 wins the next tie
    logic             grant_p0, grant_p1, grant_ref;
    logic             cmd_done;
    logic             ref_done;

    assign ref_wrap = (ref_cnt == CNT_MAX);
    assign cmd_done = (state == BUSY) && sdr_ack;   // acks outside BUSY are ignored
    assign ref_done = cmd_done && (owner == OWN_REF);

    // Free-running refresh timer; a single pending flag, no queuing of missed refreshes.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt     <= '0;
            ref_pend    <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + CNT_W'(1);
            if (ref_wrap) begin
                // Set takes priority over a same-cycle clear.
                ref_pend <= 1'b1;
                if (ref_pend) begin
                    ref_overrun <= 1'b1;
                end
            end else if (ref_done) begin
                ref_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_p0  = 1'b0;
        grant_p1  = 1'b0;
        grant_ref = 1'b0;
        case (state)
            IDLE: begin
                if (ref_pend) begin
                    grant_ref = 1'b1;
                end else if (p0_req && p1_req) begin
                    grant_p0 = last_p1;
                    grant_p1 = !last_p1;
                end else begin
                    grant_p0 = p0_req;
                    grant_p1 = p1_req;
                end
                if (grant_ref || grant_p0 || grant_p1) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (sdr_ack) begin
                    state_nxt = DONE;
                end
            end
            // Gap cycle lets a requester that just saw its ack drop req before re-arbitration.
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWN_P0;
            last_p1   <= 1'b1;
            sdr_req   <= 1'b0;
            sdr_ref   <= 1'b0;
            sdr_we    <= 1'b0;
            sdr_addr  <= '0;
            sdr_wdata <= '0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;

            if (grant_ref) begin
                // Address/data are don't-care downstream for refresh, so they are left as they were.
                sdr_req <= 1'b1;
                sdr_ref <= 1'b1;
                sdr_we  <= 1'b0;
                owner   <= OWN_REF;
            end else if (grant_p0) begin
                sdr_req   <= 1'b1;
                sdr_ref   <= 1'b0;
                sdr_we    <= p0_we;
                sdr_addr  <= p0_addr;
                sdr_wdata <= p0_wdata;
                owner     <= OWN_P0;
            end else if (grant_p1) begin
                sdr_req   <= 1'b1;
                sdr_ref   <= 1'b0;
                sdr_we    <= p1_we;
                sdr_addr  <= p1_addr;
                sdr_wdata <= p1_wdata;
                owner     <= OWN_P1;
            end

            if (cmd_done) begin
                sdr_req <= 1'b0;
                sdr_ref <= 1'b0;
                // rdata is captured for writes too; its value is simply meaningless then.
                case (owner)
                    OWN_P0: begin
                        p0_rdata <= sdr_rdata;
                        p0_ack   <= 1'b1;
                        last_p1  <= 1'b0;
                    end
                    OWN_P1: begin
                        p1_rdata <= sdr_rdata;
                        p1_ack   <= 1'b1;
                        last_p1  <= 1'b1;
                    end
                    default: ;   // refresh leaves the round-robin pointer alone
                endcase
            end
        end
    end

endmodule
